// File: rtl/lifo_pop_buffer_if.sv
// Signal bundle between the LIFO pop buffer, the stack it drains, and its
// downstream consumer.
//
// Handshake (output side): an item moves on every rising edge where
// output_valid && output_ready are both high. output_valid never depends on
// output_ready. output_data is held stable while output_valid=1 and
// output_ready=0. On the stack side, every cycle with lifo_read_enable high
// pops exactly one item, and lifo_read_data is taken on that same edge.
interface lifo_pop_buffer_if #(
  parameter int WIDTH = 8
);
  logic             lifo_empty;
  logic             lifo_read_enable;
  logic [WIDTH-1:0] lifo_read_data;
  logic             output_valid;
  logic             output_ready;
  logic [WIDTH-1:0] output_data;
  logic [1:0]       buffered_count;

  // View seen by the pop buffer itself.
  modport slave (
    input  lifo_empty,
    input  lifo_read_data,
    input  output_ready,
    output lifo_read_enable,
    output output_valid,
    output output_data,
    output buffered_count
  );

  // View seen by the environment: the stack plus the consumer.
  modport master (
    output lifo_empty,
    output lifo_read_data,
    output output_ready,
    input  lifo_read_enable,
    input  output_valid,
    input  output_data,
    input  buffered_count
  );
endinterface

// File: rtl/lifo_pop_buffer.sv
// LIFO pop buffer: pops items from a stack's combinational top-of-stack port
// and presents them as a registered valid/ready stream. Two entries of storage
// allow one item per cycle. The pop strobe depends only on the registered
// occupancy, so output_ready has no combinational path to lifo_read_enable.
module lifo_pop_buffer #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_flush,
  lifo_pop_buffer_if.slave     bus,
  output logic [1:0]           o_dbg_state
);

  // The state encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    ST_ZERO = 2'd0,
    ST_ONE  = 2'd1,
    ST_TWO  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  logic [WIDTH-1:0] w_slot0_nxt;
  logic [WIDTH-1:0] w_slot1_nxt;
  logic             w_pop;
  logic             w_take;

  // Pop whenever there is room. Reset also blocks the pop, so no item is
  // removed from the stack only to be thrown away by the reset.
  assign w_pop  = !bus.lifo_empty && !i_flush && !i_reset && (r_state != ST_TWO);
  assign w_take = (r_state != ST_ZERO) && bus.output_ready;

  // State and slot registers; reset clears everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_ZERO;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
    end
  end

  // Next occupancy and slot contents. slot0 is always the oldest entry.
  always_comb begin
    w_state_nxt = r_state;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    case (r_state)
      ST_ZERO: begin
        if (w_pop) begin
          w_slot0_nxt = bus.lifo_read_data;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_pop && w_take) begin
          w_slot0_nxt = bus.lifo_read_data;
          w_state_nxt = ST_ONE;
        end else if (w_pop) begin
          w_slot1_nxt = bus.lifo_read_data;
          w_state_nxt = ST_TWO;
        end else if (w_take) begin
          w_state_nxt = ST_ZERO;
        end
      end
      ST_TWO: begin
        if (w_take) begin
          w_slot0_nxt = r_slot1;
          w_state_nxt = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_ZERO;
      end
    endcase
    // A flush discards whatever is left after this cycle's take; the slots
    // keep stale data that is never shown because valid drops.
    if (i_flush) begin
      w_state_nxt = ST_ZERO;
    end
  end

  assign bus.lifo_read_enable = w_pop;
  assign bus.output_valid     = (r_state != ST_ZERO);
  assign bus.output_data      = r_slot0;
  assign bus.buffered_count   = r_state;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_lifo_pop_buffer.sv
// Bench for lifo_pop_buffer: models the upstream stack as a queue and the
// buffer as an ordered FIFO of popped items; directed scenarios followed by
// randomized traffic with pushes, flushes and resets.
module tb_lifo_pop_buffer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [1:0]   dbg_state;
  logic         push_en;
  logic [W-1:0] push_val;

  logic [W-1:0] stk[$];    // upstream stack, top is the last element
  logic [W-1:0] exp_q[$];  // items held by the buffer, oldest first

  int n_total = 0;
  int n_bad   = 0;

  lifo_pop_buffer_if #(.WIDTH(W)) bus ();

  lifo_pop_buffer #(.WIDTH(W)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_flush    (flush),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_stack();
    bus.lifo_empty     = (stk.size() == 0);
    bus.lifo_read_data = (stk.size() != 0) ? stk[stk.size()-1] : '0;
  endtask

  // One clock cycle: compare outputs against the model mid-cycle, then
  // advance the stack and the model across the rising edge.
  task automatic cycle();
    bit           exp_pop;
    bit           exp_take;
    bit           act_pop;
    logic [W-1:0] top;
    drive_stack();
    @(negedge clk);
    exp_pop  = !rst && !flush && (stk.size() != 0) && (exp_q.size() < 2);
    exp_take = (exp_q.size() != 0) && bus.output_ready;
    check_eq("rd_en", {31'd0, bus.lifo_read_enable}, {31'd0, exp_pop});
    check_eq("valid", {31'd0, bus.output_valid}, {31'd0, exp_q.size() != 0});
    check_eq("count", {30'd0, bus.buffered_count}, exp_q.size());
    check_eq("dbg_state", {30'd0, dbg_state}, exp_q.size());
    if (exp_q.size() != 0)
      check_eq("data", {24'd0, bus.output_data}, {24'd0, exp_q[0]});
    act_pop = bus.lifo_read_enable;
    top     = bus.lifo_read_data;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_take) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      if (exp_pop) exp_q.push_back(top);
    end
    // Stack: a pop reads the pre-write top, then any push lands on top.
    if (act_pop && stk.size() != 0) void'(stk.pop_back());
    if (push_en) stk.push_back(push_val);
    push_en = 1'b0;
    drive_stack();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    push_en          = 1'b0;
    push_val         = '0;
    bus.output_ready = 1'b0;
    drive_stack();
    @(posedge clk);
    #1;
    cycle();
    check_eq("reset_data", {24'd0, bus.output_data}, 32'd0);
    check_eq("reset_valid", {31'd0, bus.output_valid}, 32'd0);

    // 1: empty stack after reset
    rst = 1'b0;
    run(5);

    // 2: A3 on top, consumer always ready
    stk.push_back(8'hA1); stk.push_back(8'hA2); stk.push_back(8'hA3);
    bus.output_ready = 1'b1;
    run(5);

    // 3: consumer stalled, buffer fills, then drains
    stk.push_back(8'h33); stk.push_back(8'h22); stk.push_back(8'h11);
    bus.output_ready = 1'b0;
    run(4);
    check_eq("stall_count", {30'd0, bus.buffered_count}, 32'd2);
    bus.output_ready = 1'b1;
    run(5);

    // 4: full buffer, ready toggling
    for (int i = 0; i < 8; i++) stk.push_back(8'h40 + 8'(i));
    bus.output_ready = 1'b0;
    run(3);
    for (int i = 0; i < 12; i++) begin
      bus.output_ready = i[0];
      cycle();
    end

    // 5: flush while full with a take in the same cycle
    for (int i = 0; i < 4; i++) stk.push_back(8'h60 + 8'(i));
    bus.output_ready = 1'b0;
    run(3);
    flush = 1'b1;
    bus.output_ready = 1'b1;
    cycle();
    flush = 1'b0;
    bus.output_ready = 1'b0;
    check_eq("flush_valid", {31'd0, bus.output_valid}, 32'd0);
    check_eq("flush_count", {30'd0, bus.buffered_count}, 32'd0);
    run(2);

    // 6: reset mid-stream at count 1
    stk.delete();
    for (int i = 0; i < 6; i++) stk.push_back(8'h80 + 8'(i));
    bus.output_ready = 1'b1;
    run(4);
    rst = 1'b1;
    cycle();
    check_eq("rst_valid", {31'd0, bus.output_valid}, 32'd0);
    check_eq("rst_data", {24'd0, bus.output_data}, 32'd0);
    check_eq("rst_rd_en", {31'd0, bus.lifo_read_enable}, 32'd0);
    check_eq("rst_count", {30'd0, bus.buffered_count}, 32'd0);
    rst = 1'b0;
    run(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      push_en          = (stk.size() < 16) && ($urandom_range(0, 2) != 0);
      push_val         = W'($urandom);
      bus.output_ready = ($urandom_range(0, 3) != 0);
      flush            = ($urandom_range(0, 19) == 0);
      rst              = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst   = 1'b0;
    flush = 1'b0;
    bus.output_ready = 1'b1;
    run(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
